// File: rtl/ser_tx_nb.sv
// Parallel-in, serial-out transmitter with MSB/LSB-first order and an exported per-cycle register opcode.
// Define SER_TX_PARITY_EN to append an even-parity bit after the data bits.
module ser_tx_nb #(
    parameter int   n        = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] data_in,
    input  logic         start,
    input  logic         dir,
    input  logic         tick,
    output logic         sout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   sel
);

    localparam int CW = $clog2(n);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, PAR = 2'b10} state_t;

    function automatic logic even_par(input logic [n-1:0] w);
        return ^w;
    endfunction

    logic par_r;
`else
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;
`endif

    state_t         state_r, next_state_s;
    logic [n-1:0]   shreg_r;
    logic [CW-1:0]  count_r;
    logic           dir_r;
    logic           done_r;
    logic           last_s;
    logic           fin_s;
    logic [1:0]     sel_s;
    logic           busy_s;
    logic           sout_s;

    assign last_s = (count_r == CW'(n - 1));

    // Next-state, opcode and serial output decode
    always_comb begin
        next_state_s = state_r;
        sel_s        = 2'b00;
        busy_s       = 1'b0;
        sout_s       = IDLE_LVL;
        fin_s        = 1'b0;
        case (state_r)
            IDLE: begin
                // a tick arriving alongside start is not a bit period
                if (start) begin
                    sel_s        = 2'b01;
                    next_state_s = SHIFT;
                end else begin
                    sel_s        = 2'b00;
                end
            end
            SHIFT: begin
                busy_s = 1'b1;
                sout_s = dir_r ? shreg_r[0] : shreg_r[n-1];
                if (tick) begin
                    sel_s = dir_r ? 2'b11 : 2'b10;
                    if (last_s) begin
`ifdef SER_TX_PARITY_EN
                        next_state_s = PAR;
`else
                        next_state_s = IDLE;
                        fin_s        = 1'b1;
`endif
                    end else begin
                        next_state_s = SHIFT;
                    end
                end else begin
                    sel_s = 2'b00;
                end
            end
`ifdef SER_TX_PARITY_EN
            PAR: begin
                busy_s = 1'b1;
                sout_s = par_r;
                if (tick) begin
                    next_state_s = IDLE;
                    fin_s        = 1'b1;
                end else begin
                    next_state_s = PAR;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and registered done pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= fin_s;
        end
    end

    // Shift register, bit counter and captured direction, steered by the exported opcode
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg_r <= '0;
            count_r <= '0;
            dir_r   <= 1'b0;
        end else begin
            case (sel_s)
                2'b01: begin
                    shreg_r <= data_in;
                    dir_r   <= dir;
                    count_r <= '0;
                end
                2'b10: begin
                    shreg_r <= {shreg_r[n-2:0], 1'b0};
                    count_r <= last_s ? '0 : count_r + CW'(1);
                end
                2'b11: begin
                    shreg_r <= {1'b0, shreg_r[n-1:1]};
                    count_r <= last_s ? '0 : count_r + CW'(1);
                end
                default: begin
                    shreg_r <= shreg_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef SER_TX_PARITY_EN
    // Parity of the captured word, frozen at load
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_r <= 1'b0;
        end else if (sel_s == 2'b01) begin
            par_r <= even_par(data_in);
        end else begin
            par_r <= par_r;
        end
    end
`endif

    assign sout = sout_s;
    assign busy = busy_s;
    assign done = done_r;
    assign sel  = sel_s;

endmodule
